// File: rtl/timer_ctrl_pkg.sv
// Shared constants for the step-counter family: counter boundary modes and
// the default geometry used when a counter instance is not parameterised.
// No ports; imported by the counter and its bench.
package timer_ctrl_pkg;

  // Behaviour at the count bounds
  localparam int CNT_SATURATE = 0;  // hold at 0 / MAX_VAL
  localparam int CNT_WRAP     = 1;  // roll over to the opposite bound

  // Default geometry
  localparam int DEF_WIDTH   = 3;
  localparam int DEF_MAX_VAL = 7;
  localparam int DEF_TAP_VAL = 4;

endpackage

// File: rtl/param_step_counter.sv
// Up/down step counter with clear/load, bounded at MAX_VAL, saturating or
// wrapping at the bounds, with one-cycle tap (stepped onto TAP_VAL) and wrap flags.
// Latency: count/tap_pulse/wrap_pulse register on the stepping edge; at_max/at_zero
// decode count combinationally. No backpressure: one step per enabled cycle.
// Ports:
//   clock      - single clock, all state on the rising edge
//   clear      - synchronous active-high reset, highest priority
//   enable/up  - step request and direction (1 = increment)
//   load       - synchronous preset to min(load_val, MAX_VAL)
//   count      - registered count
//   tap_pulse  - one cycle: the last edge stepped count onto TAP_VAL
//   wrap_pulse - one cycle: the last edge wrapped count across a bound
//   at_max     - count == MAX_VAL
//   at_zero    - count == 0
module param_step_counter
  import timer_ctrl_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MAX_VAL = DEF_MAX_VAL,
  parameter int TAP_VAL = DEF_TAP_VAL,
  parameter int WRAP    = CNT_SATURATE
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tap_pulse,
  output logic             wrap_pulse,
  output logic             at_max,
  output logic             at_zero
);

  // Reject geometries the counter cannot represent.
  if (MAX_VAL > (2**WIDTH) - 1) begin : g_bad_max
    $error("param_step_counter: MAX_VAL does not fit in WIDTH bits");
  end
  if (TAP_VAL > MAX_VAL) begin : g_bad_tap
    $error("param_step_counter: TAP_VAL exceeds MAX_VAL");
  end
  if (MAX_VAL == 0) begin : g_bad_zero
    $error("param_step_counter: MAX_VAL must be non-zero");
  end

  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] TAP_W  = WIDTH'(TAP_VAL);
  localparam logic [WIDTH-1:0] ZERO_W = '0;
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tap_q, tap_d;
  logic             wrap_q, wrap_d;
  logic             stepped;

  always_comb begin
    count_d = count_q;
    tap_d   = 1'b0;
    wrap_d  = 1'b0;
    stepped = 1'b0;
    if (clear) begin
      count_d = ZERO_W;
    end else if (load) begin
      // Loads clamp to the bound and never raise a pulse.
      count_d = (load_val > MAX_W) ? MAX_W : load_val;
    end else if (enable) begin
      if (up) begin
        if (count_q < MAX_W) begin
          count_d = count_q + ONE_W;
          stepped = 1'b1;
        end else if (WRAP == CNT_WRAP) begin
          count_d = ZERO_W;
          wrap_d  = 1'b1;
          stepped = 1'b1;
        end
      end else begin
        if (count_q > ZERO_W) begin
          count_d = count_q - ONE_W;
          stepped = 1'b1;
        end else if (WRAP == CNT_WRAP) begin
          count_d = MAX_W;
          wrap_d  = 1'b1;
          stepped = 1'b1;
        end
      end
      // A saturated hold at TAP_VAL is not a step onto it.
      tap_d = stepped && (count_d == TAP_W) && (count_d != count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= ZERO_W;
      tap_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tap_q   <= tap_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count      = count_q;
  assign tap_pulse  = tap_q;
  assign wrap_pulse = wrap_q;
  assign at_max     = (count_q == MAX_W);
  assign at_zero    = (count_q == ZERO_W);

endmodule

// File: tb/tb_param_step_counter.sv
// Bench for param_step_counter: two instances on shared stimulus, u0 with the
// default saturating geometry (MAX 7, TAP 4) and u1 wrapping with MAX 5, TAP 4.
// Directed vectors with hand-computed expectations, sampled #1 after each edge.
module tb_param_step_counter;
  import timer_ctrl_pkg::*;

  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [2:0] load_val = 3'd0;

  logic [2:0] c0, c1;
  logic       t0, t1, w0, w1, m0, m1, z0, z1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  param_step_counter u0 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_val(load_val), .count(c0), .tap_pulse(t0), .wrap_pulse(w0),
    .at_max(m0), .at_zero(z0)
  );

  param_step_counter #(.WIDTH(3), .MAX_VAL(5), .TAP_VAL(4), .WRAP(CNT_WRAP)) u1 (
    .clock(clock), .clear(clear), .enable(enable), .up(up), .load(load),
    .load_val(load_val), .count(c1), .tap_pulse(t1), .wrap_pulse(w1),
    .at_max(m1), .at_zero(z1)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1; load = 1'b0; enable = 1'b0;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1; load = 1'b1; load_val = 3'd6; enable = 1'b1; up = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    total++; if (c0 !== 3'd0) begin bad++; $display("FAIL reset u0 count: got %0d want 0", c0); end
    total++; if (t0 !== 1'b0 || w0 !== 1'b0) begin bad++; $display("FAIL reset u0 pulses: got tap=%b wrap=%b want 0 0", t0, w0); end
    total++; if (z0 !== 1'b1 || m0 !== 1'b0) begin bad++; $display("FAIL reset u0 flags: got zero=%b max=%b want 1 0", z0, m0); end
    total++; if (c1 !== 3'd0 || t1 !== 1'b0 || w1 !== 1'b0) begin bad++; $display("FAIL reset u1: got count=%0d tap=%b wrap=%b want 0 0 0", c1, t1, w1); end
  endtask

  // Ten up-steps: u0 saturates at 7, u1 wraps 5->0.
  task automatic test_count_up();
    int e0 [10];
    int e1 [10];
    e0 = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
    e1 = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4};
    do_clear();
    enable = 1'b1; up = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (c0 !== 3'(e0[i])) begin bad++; $display("FAIL up_sat u0 count step %0d: got %0d want %0d", i, c0, e0[i]); end
      total++; if (t0 !== (i == 3)) begin bad++; $display("FAIL up_sat u0 tap step %0d: got %b want %b", i, t0, (i == 3)); end
      total++; if (w0 !== 1'b0) begin bad++; $display("FAIL up_sat u0 wrap step %0d: got %b want 0", i, w0); end
      total++; if (c1 !== 3'(e1[i])) begin bad++; $display("FAIL up_wrap u1 count step %0d: got %0d want %0d", i, c1, e1[i]); end
      total++; if (t1 !== (i == 3 || i == 9)) begin bad++; $display("FAIL up_wrap u1 tap step %0d: got %b want %b", i, t1, (i == 3 || i == 9)); end
      total++; if (w1 !== (i == 5)) begin bad++; $display("FAIL up_wrap u1 wrap step %0d: got %b want %b", i, w1, (i == 5)); end
    end
    total++; if (m0 !== 1'b1) begin bad++; $display("FAIL up_sat u0 at_max: got %b want 1", m0); end
    enable = 1'b0;
  endtask

  // Step down from 0: u0 holds, u1 wraps to MAX_VAL.
  task automatic test_down_wrap();
    do_clear();
    enable = 1'b1; up = 1'b0;
    tick();
    enable = 1'b0;
    total++; if (c0 !== 3'd0 || z0 !== 1'b1 || w0 !== 1'b0) begin bad++; $display("FAIL down0 u0: got count=%0d zero=%b wrap=%b want 0 1 0", c0, z0, w0); end
    total++; if (c1 !== 3'd5 || w1 !== 1'b1 || m1 !== 1'b1) begin bad++; $display("FAIL down0 u1: got count=%0d wrap=%b max=%b want 5 1 1", c1, w1, m1); end
    tick();
    total++; if (c1 !== 3'd5 || w1 !== 1'b0) begin bad++; $display("FAIL down0 u1 hold: got count=%0d wrap=%b want 5 0", c1, w1); end
  endtask

  // Load beats enable, clamps to MAX_VAL, and never pulses.
  task automatic test_load();
    do_clear();
    load = 1'b1; load_val = 3'd4; enable = 1'b1; up = 1'b1;
    tick();
    total++; if (c0 !== 3'd4 || t0 !== 1'b0) begin bad++; $display("FAIL load4 u0: got count=%0d tap=%b want 4 0", c0, t0); end
    total++; if (c1 !== 3'd4 || t1 !== 1'b0) begin bad++; $display("FAIL load4 u1: got count=%0d tap=%b want 4 0", c1, t1); end
    load_val = 3'd7;
    tick();
    load = 1'b0; enable = 1'b0;
    total++; if (c0 !== 3'd7 || m0 !== 1'b1) begin bad++; $display("FAIL load7 u0: got count=%0d max=%b want 7 1", c0, m0); end
    total++; if (c1 !== 3'd5 || m1 !== 1'b1 || w1 !== 1'b0) begin bad++; $display("FAIL load7 u1 clamp: got count=%0d max=%b wrap=%b want 5 1 0", c1, m1, w1); end
  endtask

  // Clear overrides a simultaneous load and step, then counting restarts at 0.
  task automatic test_clear_priority();
    do_clear();
    load = 1'b1; load_val = 3'd3;
    tick();
    total++; if (c0 !== 3'd3 || c1 !== 3'd3) begin bad++; $display("FAIL clrpri setup: got u0=%0d u1=%0d want 3 3", c0, c1); end
    clear = 1'b1; load = 1'b1; load_val = 3'd6; enable = 1'b1; up = 1'b1;
    tick();
    total++; if (c0 !== 3'd0 || t0 !== 1'b0 || w0 !== 1'b0) begin bad++; $display("FAIL clrpri u0: got count=%0d tap=%b wrap=%b want 0 0 0", c0, t0, w0); end
    total++; if (c1 !== 3'd0 || t1 !== 1'b0 || w1 !== 1'b0) begin bad++; $display("FAIL clrpri u1: got count=%0d tap=%b wrap=%b want 0 0 0", c1, t1, w1); end
    clear = 1'b0; load = 1'b0;
    tick();
    enable = 1'b0;
    total++; if (c0 !== 3'd1 || c1 !== 3'd1) begin bad++; $display("FAIL clrpri resume: got u0=%0d u1=%0d want 1 1", c0, c1); end
  endtask

  // Down from 6 (u1 clamps to 5): tap only on stepping onto 4, not while holding.
  task automatic test_down_tap();
    int e0 [3];
    int e1 [3];
    logic p0 [3];
    logic p1 [3];
    e0 = '{5, 4, 3};
    e1 = '{4, 3, 2};
    p0 = '{1'b0, 1'b1, 1'b0};
    p1 = '{1'b1, 1'b0, 1'b0};
    do_clear();
    load = 1'b1; load_val = 3'd6;
    tick();
    load = 1'b0; enable = 1'b1; up = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (c0 !== 3'(e0[i]) || t0 !== p0[i]) begin bad++; $display("FAIL down_tap u0 step %0d: got count=%0d tap=%b want %0d %b", i, c0, t0, e0[i], p0[i]); end
      total++; if (c1 !== 3'(e1[i]) || t1 !== p1[i]) begin bad++; $display("FAIL down_tap u1 step %0d: got count=%0d tap=%b want %0d %b", i, c1, t1, e1[i], p1[i]); end
    end
    enable = 1'b0;
    tick();
    total++; if (c0 !== 3'd4 || t0 !== 1'b0 || w0 !== 1'b0) begin bad++; $display("FAIL hold_tap u0: got count=%0d tap=%b wrap=%b want 4 0 0", c0, t0, w0); end
    total++; if (c1 !== 3'd3 || t1 !== 1'b0) begin bad++; $display("FAIL hold_tap u1: got count=%0d tap=%b want 3 0", c1, t1); end
    enable = 1'b1;
    tick();
    enable = 1'b0;
    total++; if (c0 !== 3'(e0[2]) || t0 !== p0[2]) begin bad++; $display("FAIL down_tap u0 step 2: got count=%0d tap=%b want %0d %b", c0, t0, e0[2], p0[2]); end
    total++; if (c1 !== 3'(e1[2]) || t1 !== p1[2]) begin bad++; $display("FAIL down_tap u1 step 2: got count=%0d tap=%b want %0d %b", c1, t1, e1[2], p1[2]); end
  endtask

  initial begin
    #2;
    test_reset();
    test_count_up();
    test_down_wrap();
    test_load();
    test_clear_priority();
    test_down_tap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_step_counter.md
PARAM_STEP_COUNTER -- requirements
Module: param_step_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 3, count register width in bits.
REQ-002 SHALL have parameter MAX_VAL, default 7, upper count bound.
REQ-003 SHALL have parameter TAP_VAL, default 4, count value that raises tap_pulse.
REQ-004 SHALL have parameter WRAP, default 0; 0 = saturate at bounds, 1 = wrap around.
REQ-005 SHALL have port clock  in  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port clear  in  1  reset; synchronous, active-high.
REQ-007 SHALL have port enable  in  1  step request; one step per cycle while high.
REQ-008 SHALL have port up  in  1  direction; 1 = increment, 0 = decrement.
REQ-009 SHALL have port load  in  1  synchronous preset strobe.
REQ-010 SHALL have port load_val  in  WIDTH  preset value.
REQ-011 SHALL have port count  out  WIDTH  current count, registered.
REQ-012 SHALL have port tap_pulse  out  1  registered one-cycle flag; count stepped onto TAP_VAL.
REQ-013 SHALL have port wrap_pulse  out  1  registered one-cycle flag; count wrapped.
REQ-014 SHALL have port at_max  out  1  combinational: count == MAX_VAL.
REQ-015 SHALL have port at_zero  out  1  combinational: count == 0.

Function
REQ-016 Per-edge priority SHALL be clear > load > enable step > hold.
REQ-017 load SHALL set count to min(load_val, MAX_VAL); tap_pulse and wrap_pulse = 0 that cycle.
REQ-018 Step up with count < MAX_VAL SHALL give count+1; step down with count > 0 SHALL give count-1.
REQ-019 Step up at MAX_VAL: WRAP=0 holds MAX_VAL; WRAP=1 goes to 0 and sets wrap_pulse for one cycle.
REQ-020 Step down at 0: WRAP=0 holds 0; WRAP=1 goes to MAX_VAL and sets wrap_pulse for one cycle.
REQ-021 tap_pulse SHALL be 1 after an edge only if that edge stepped count to TAP_VAL from a different value; otherwise 0.
REQ-022 tap_pulse SHALL stay 0 when count merely holds at TAP_VAL (saturated, enable low) or is loaded to TAP_VAL.
REQ-023 Latency: count, tap_pulse, wrap_pulse update on the same edge as the step; at_max/at_zero follow count with zero delay.
REQ-024 enable low (no load, no clear) SHALL hold count and drive both pulses 0.
REQ-025 Arithmetic SHALL be unsigned WIDTH-bit with no intermediate overflow; count never exceeds MAX_VAL.
REQ-026 Elaboration SHALL fail if MAX_VAL > 2**WIDTH-1, TAP_VAL > MAX_VAL, or MAX_VAL == 0.

Reset
REQ-027 clear high at an edge SHALL set count=0, tap_pulse=0, wrap_pulse=0, overriding load and enable.
REQ-028 clear mid-count SHALL abort the count without a wrap_pulse or tap_pulse; counting resumes from 0 on the first enabled edge after clear falls.
REQ-029 Initial state before the first clear is undefined; the first clear SHALL establish all reset values.

Structure
REQ-030 Shared package timer_ctrl_pkg SHALL hold mode constants CNT_SATURATE=0 and CNT_WRAP=1 plus default WIDTH/MAX_VAL/TAP_VAL constants.
REQ-031 Single flat module; no sub-module; next-count logic is one combinational block.

Verification
REQ-032 Defaults (WRAP=0), clear then enable=1 up=1 for 10 cycles -> count 1..7 then holds 7; tap_pulse high only the cycle count=4; wrap_pulse never.
REQ-033 WRAP=1, MAX_VAL=5, up from 0 for 7 steps -> count 1,2,3,4,5,0,1; wrap_pulse high only the cycle count=0.
REQ-034 WRAP=1, up=0 from 0 -> count MAX_VAL, wrap_pulse=1; WRAP=0 up=0 at 0 -> holds 0, at_zero=1.
REQ-035 load=1 load_val=4 with enable=1 -> count=4, tap_pulse=0; load_val=7 with MAX_VAL=5 -> count=5.
REQ-036 clear=1 together with load=1 enable=1 at count=3 -> count=0, pulses 0; then enable up -> count=1.
REQ-037 Down count from 6, TAP_VAL=4 -> tap_pulse on stepping 5->4 only; holding at 4 with enable=0 -> tap_pulse=0.
